obufds_gte3_switch: RTL and testbench

OBUFDS_GTE3_SWITCH -- requirements
Module: obufds_gte3_switch

---
 rtl/obufds_gte3_pkg.sv | 21 ++
 rtl/gte3_cycle_cnt.sv | 27 ++
 rtl/obufds_gte3_switch.sv | 134 +++++++++++++
 tb/tb_obufds_gte3_switch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/obufds_gte3_pkg.sv
// Shared state encodings and sizing helpers for the GTE3 reference-clock output switch.
package obufds_gte3_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned NumSrc = 4;
    localparam int unsigned SelW   = 2;

    localparam logic [StateW-1:0] StOff    = 3'd0;
    localparam logic [StateW-1:0] StSettle = 3'd1;
    localparam logic [StateW-1:0] StOn     = 3'd2;
    localparam logic [StateW-1:0] StDrain  = 3'd3;
    localparam logic [StateW-1:0] StSwitch = 3'd4;

    // Counter must hold the longer of the two gated-off intervals.
    function automatic int unsigned cnt_width(input int unsigned drain, input int unsigned settle);
        int unsigned longest;
        longest = (drain > settle) ? drain : settle;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/gte3_cycle_cnt.sv
// Down-counter timing the DRAIN and SETTLE intervals; loads on state entry, saturates at zero.
module gte3_cycle_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/obufds_gte3_switch.sv
// Glitch-free source selector for a differential reference-clock output buffer: the output is
// gated off while draining, switching and settling, and the selection only changes while gated.
module obufds_gte3_switch
    import obufds_gte3_pkg::*;
#(
    parameter logic [0:0]  REFCLK_EN_TX_PATH = 1'b1,
    parameter logic [1:0]  RXRECCLK_SEL_INIT = 2'b00,
    parameter int unsigned DRAIN_CYCLES      = 4,
    parameter int unsigned SETTLE_CYCLES     = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NumSrc-1:0] I,
    input  logic              CEB,
    input  logic              EN,
    input  logic [SelW-1:0]   SEL_REQ,
    input  logic              SEL_VALID,
    output logic              SEL_READY,
    output logic [SelW-1:0]   SEL_CUR,
    output logic              O,
    output logic              OB,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned CntW = cnt_width(DRAIN_CYCLES, SETTLE_CYCLES);

    logic [StateW-1:0] state_q, state_d;
    logic [SelW-1:0]   sel_cur_q, sel_cur_d;
    logic [SelW-1:0]   pend_q, pend_d;
    logic              done_q, done_d;
    logic              en_ok, accept, gate;
    logic              cnt_zero, cnt_load, cnt_en;
    logic [CntW-1:0]   cnt_val;

    assign en_ok     = EN & ~CEB & REFCLK_EN_TX_PATH[0];
    assign SEL_READY = (state_q == StOff) | ((state_q == StOn) & en_ok);
    assign accept    = SEL_VALID & SEL_READY;

    always_comb begin
        state_d   = state_q;
        sel_cur_d = sel_cur_q;
        pend_d    = pend_q;
        done_d    = 1'b0;
        if (accept) begin
            pend_d = SEL_REQ;
        end
        unique case (state_q)
            StOff: begin
                // Selection and enable may both take effect on the same edge.
                if (accept) begin
                    sel_cur_d = SEL_REQ;
                    done_d    = 1'b1;
                end
                if (en_ok) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!en_ok) begin
                    state_d = StOff;
                end else if (cnt_zero) begin
                    state_d = StOn;
                end
            end
            StOn: begin
                if (!en_ok) begin
                    state_d = StOff;
                end else if (accept) begin
                    if (SEL_REQ == sel_cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // A disable while draining still commits the pending source.
                if (!en_ok) begin
                    state_d   = StOff;
                    sel_cur_d = pend_q;
                    done_d    = 1'b1;
                end else if (cnt_zero) begin
                    state_d = StSwitch;
                end
            end
            StSwitch: begin
                sel_cur_d = pend_q;
                done_d    = 1'b1;
                state_d   = en_ok ? StSettle : StOff;
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    assign cnt_load = (state_d != state_q) && ((state_d == StDrain) || (state_d == StSettle));
    assign cnt_val  = (state_d == StDrain) ? CntW'(DRAIN_CYCLES - 1) : CntW'(SETTLE_CYCLES - 1);
    assign cnt_en   = (state_q == StDrain) || (state_q == StSettle);

    gte3_cycle_cnt #(
        .Width (CntW)
    ) u_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StOff;
            sel_cur_q <= RXRECCLK_SEL_INIT;
            pend_q    <= RXRECCLK_SEL_INIT;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_cur_q <= sel_cur_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
        end
    end

    assign gate    = (state_q == StOn);
    assign O       = gate & I[sel_cur_q];
    assign OB      = gate & ~I[sel_cur_q];
    assign SEL_CUR = sel_cur_q;
    assign BUSY    = (state_q == StSettle) | (state_q == StDrain) | (state_q == StSwitch);
    assign DONE    = done_q;

endmodule

// File: tb/tb_obufds_gte3_switch.sv
// Bench for obufds_gte3_switch: a default instance and a TX-path-disabled instance share stimulus
// and are compared each cycle against a timestamp-based model of enable and switch latencies.
module tb_obufds_gte3_switch;

    localparam int unsigned Drain  = 4;
    localparam int unsigned Settle = 8;
    localparam logic [1:0]  InitB  = 2'd2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] I;
    logic       CEB, EN, SEL_VALID;
    logic [1:0] SEL_REQ;

    logic       rdy_a, o_a, ob_a, busy_a, done_a;
    logic [1:0] cur_a;
    logic       rdy_b, o_b, ob_b, busy_b, done_b;
    logic [1:0] cur_b;

    always #5 CLK = ~CLK;

    obufds_gte3_switch dut (
        .CLK (CLK), .RST_N (RST_N), .I (I), .CEB (CEB), .EN (EN),
        .SEL_REQ (SEL_REQ), .SEL_VALID (SEL_VALID), .SEL_READY (rdy_a), .SEL_CUR (cur_a),
        .O (o_a), .OB (ob_a), .BUSY (busy_a), .DONE (done_a)
    );

    obufds_gte3_switch #(
        .REFCLK_EN_TX_PATH (1'b0),
        .RXRECCLK_SEL_INIT (InitB)
    ) dut_notx (
        .CLK (CLK), .RST_N (RST_N), .I (I), .CEB (CEB), .EN (EN),
        .SEL_REQ (SEL_REQ), .SEL_VALID (SEL_VALID), .SEL_READY (rdy_b), .SEL_CUR (cur_b),
        .O (o_b), .OB (ob_b), .BUSY (busy_b), .DONE (done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: edges since reset, and the edge after which the gate opens / the source commits.
    int         cyc;
    int         on_at;
    int         swap_at;
    bit         active;
    logic [1:0] m_cur, m_pend, m2_cur;
    bit         m_done, m2_done;

    function automatic bit m_gate();
        return active && (cyc >= on_at);
    endfunction

    task automatic model_reset();
        cyc     = 0;
        on_at   = 0;
        swap_at = -1;
        active  = 0;
        m_cur   = 2'd0;
        m_pend  = 2'd0;
        m_done  = 0;
        m2_cur  = InitB;
        m2_done = 0;
    endtask

    task automatic check_outputs();
        bit g  = m_gate();
        bit ok = EN && !CEB;
        check("ready",   32'(rdy_a),  32'(!active || (g && ok)));
        check("sel_cur", 32'(cur_a),  32'(m_cur));
        check("o",       32'(o_a),    32'(g && I[m_cur]));
        check("ob",      32'(ob_a),   32'(g && !I[m_cur]));
        check("busy",    32'(busy_a), 32'(active && !g));
        check("done",    32'(done_a), 32'(m_done));
        check("b_ready", 32'(rdy_b),  32'(1));
        check("b_cur",   32'(cur_b),  32'(m2_cur));
        check("b_o",     32'(o_b),    32'(0));
        check("b_ob",    32'(ob_b),   32'(0));
        check("b_busy",  32'(busy_b), 32'(0));
        check("b_done",  32'(done_b), 32'(m2_done));
    endtask

    task automatic model_step();
        bit g   = m_gate();
        bit ok  = EN && !CEB;
        bit acc = SEL_VALID && (!active || (g && ok));
        int e   = cyc + 1;
        m_done = 0;
        if (!active) begin
            if (acc) begin
                m_cur  = SEL_REQ;
                m_done = 1;
            end
            if (ok) begin
                active  = 1;
                on_at   = e + Settle;
                swap_at = -1;
            end
        end else if (!ok) begin
            active = 0;
            if (swap_at >= 0) begin
                m_cur   = m_pend;
                m_done  = 1;
                swap_at = -1;
            end
        end else if (swap_at == e) begin
            m_cur   = m_pend;
            m_done  = 1;
            swap_at = -1;
        end else if (g && acc) begin
            if (SEL_REQ == m_cur) begin
                m_done = 1;
            end else begin
                m_pend  = SEL_REQ;
                swap_at = e + Drain + 1;
                on_at   = e + Drain + 1 + Settle;
            end
        end
        m2_done = SEL_VALID;
        if (SEL_VALID) m2_cur = SEL_REQ;
        cyc = e;
    endtask

    task automatic cycle(input bit en, input bit ceb, input bit valid, input logic [1:0] req);
        @(negedge CLK);
        EN        = en;
        CEB       = ceb;
        SEL_VALID = valid;
        SEL_REQ   = req;
        I         = 4'($urandom);
        #1 check_outputs();
        @(posedge CLK);
        model_step();
    endtask

    task automatic async_reset();
        @(negedge CLK);
        I = 4'hF;
        #2 RST_N = 1'b0;
        #1;
        check("rst_o",     32'(o_a),    32'(0));
        check("rst_ob",    32'(ob_a),   32'(0));
        check("rst_cur",   32'(cur_a),  32'(0));
        check("rst_busy",  32'(busy_a), 32'(0));
        check("rst_done",  32'(done_a), 32'(0));
        check("rst_b_cur", 32'(cur_b),  32'(InitB));
        model_reset();
        @(posedge CLK);
        #2 RST_N = 1'b1;
    endtask

    initial begin
        RST_N     = 1'b0;
        EN        = 1'b0;
        CEB       = 1'b0;
        SEL_VALID = 1'b0;
        SEL_REQ   = 2'd0;
        I         = 4'hF;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 check_outputs();
        #1 RST_N = 1'b1;

        // Enable from OFF, then steady ON on source 0.
        repeat (12) cycle(1, 0, 0, 2'd0);
        // Switch to source 2 and let it settle.
        cycle(1, 0, 1, 2'd2);
        repeat (16) cycle(1, 0, 0, 2'd0);
        // Re-select the current source: DONE only, no gating.
        cycle(1, 0, 1, 2'd2);
        repeat (3) cycle(1, 0, 0, 2'd0);
        // Force-disable mid-drain with source 3 pending.
        cycle(1, 0, 1, 2'd3);
        cycle(1, 0, 0, 2'd0);
        cycle(1, 1, 0, 2'd0);
        repeat (3) cycle(0, 0, 0, 2'd0);
        // Select while enabling from OFF, then reset during SETTLE.
        cycle(1, 0, 1, 2'd1);
        repeat (4) cycle(1, 0, 0, 2'd0);
        async_reset();
        repeat (12) cycle(1, 0, 0, 2'd0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 4) == 0, 2'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
